datamem_max_scanner: RTL and testbench

//  Sequencer that owns the data-memory port during a scan: reads LEN consecutive words from BASE_ADR,

---
 rtl/datamem_max_scanner_pkg.sv | 12 +
 rtl/datamem_max_scanner_max_tracker.sv | 33 +++
 rtl/datamem_max_scanner.sv | 92 +++++++++
 tb/tb_datamem_max_scanner.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/datamem_max_scanner_pkg.sv
// datamem_max_scanner_pkg: state encoding and default addresses shared with the memory-port mux
package datamem_max_scanner_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SCAN   = 3'd1,
    S_WR_VAL = 3'd2,
    S_WR_IDX = 3'd3,
    S_DONE   = 3'd4
  } state_t;
  localparam logic [31:0] BASE_ADR_DEF   = 32'd1000;
  localparam logic [31:0] RESULT_ADR_DEF = 32'd2000;
endpackage

// File: rtl/datamem_max_scanner_max_tracker.sv
// datamem_max_scanner_max_tracker: running signed maximum and its index
module datamem_max_scanner_max_tracker (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        first_i,
  input  logic        upd_i,
  input  logic [31:0] data_i,
  input  logic [31:0] idx_i,
  output logic [31:0] max_o,
  output logic [31:0] idx_o
);
  logic [31:0] max_q, max_d, idx_q, idx_d;
  logic take;
  // first element loads unconditionally; later ones only on strictly greater so ties keep the first
  always_comb begin
    take  = first_i | (upd_i & ($signed(data_i) > $signed(max_q)));
    max_d = clr_i ? 32'd0 : take ? data_i : max_q;
    idx_d = clr_i ? 32'hFFFF_FFFF : take ? idx_i : idx_q;
  end
  // tracker registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q <= '0;
      idx_q <= '0;
    end else begin
      max_q <= max_d;
      idx_q <= idx_d;
    end
  end
  assign max_o = max_q;
  assign idx_o = idx_q;
endmodule

// File: rtl/datamem_max_scanner.sv
// datamem_max_scanner: scans LEN words from data memory and writes back signed max and its index
module datamem_max_scanner
  import datamem_max_scanner_pkg::*;
#(
  parameter logic [31:0] BASE_ADR   = BASE_ADR_DEF,
  parameter logic [31:0] RESULT_ADR = RESULT_ADR_DEF,
  parameter int          LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      readData,
  output logic [31:0]      adr,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [31:0]      writeData,
  output logic             busy,
  output logic             done,
  output logic [31:0]      maxValue,
  output logic [31:0]      maxIndex
);
  state_t state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, i_q, i_d;
  logic [31:0] max_value_q, max_index_q, cur_max, cur_idx, i_ext;
  logic scan, wr_val, wr_idx, accept;
  assign scan   = state_q == S_SCAN;
  assign wr_val = state_q == S_WR_VAL;
  assign wr_idx = state_q == S_WR_IDX;
  assign accept = (state_q == S_IDLE) && start;
  assign i_ext  = 32'(i_q);
  // next state, length latch and element counter
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    i_d     = i_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        len_d   = len;
        i_d     = '0;
        state_d = (len == '0) ? S_WR_VAL : S_SCAN;
      end
      S_SCAN: begin
        i_d     = i_q + LEN_W'(1);
        state_d = (i_q == len_q - LEN_W'(1)) ? S_WR_VAL : S_SCAN;
      end
      S_WR_VAL: state_d = S_WR_IDX;
      S_WR_IDX: state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end
  // memory port and status are decoded from registered state only
  always_comb begin
    adr       = scan ? BASE_ADR + (i_ext << 2) : wr_val ? RESULT_ADR : wr_idx ? RESULT_ADR + 32'd4 : 32'd0;
    writeData = wr_val ? cur_max : wr_idx ? cur_idx : 32'd0;
    MemRead   = scan;
    MemWrite  = wr_val | wr_idx;
    busy      = state_q != S_IDLE;
    done      = state_q == S_DONE;
  end
  // state, counter and result registers; results become visible together with done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      i_q         <= '0;
      max_value_q <= '0;
      max_index_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      i_q     <= i_d;
      if (wr_idx) begin
        max_value_q <= cur_max;
        max_index_q <= cur_idx;
      end
    end
  end
  assign maxValue = max_value_q;
  assign maxIndex = max_index_q;
  datamem_max_scanner_max_tracker u_trk (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (accept),
    .first_i(scan && (i_q == '0)),
    .upd_i  (scan),
    .data_i (readData),
    .idx_i  (i_ext),
    .max_o  (cur_max),
    .idx_o  (cur_idx)
  );
endmodule

// File: tb/tb_datamem_max_scanner.sv
// tb_datamem_max_scanner: scoreboard bench with a behavioural memory model
module tb_datamem_max_scanner;
  logic clk = 0, rst = 1, start = 0;
  logic [15:0] len = 0;
  logic [31:0] readData, adr, writeData, maxValue, maxIndex;
  logic MemRead, MemWrite, busy, done;
  logic [31:0] mem [0:1023];
  logic [31:0] vbuf [0:15];
  typedef struct packed {logic [31:0] v; logic [31:0] x;} exp_t;
  exp_t q[$];
  exp_t pexp;
  logic pend = 0;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  datamem_max_scanner dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .readData(readData),
    .adr(adr), .MemRead(MemRead), .MemWrite(MemWrite), .writeData(writeData),
    .busy(busy), .done(done), .maxValue(maxValue), .maxIndex(maxIndex)
  );

  assign readData = mem[adr[11:2]];
  always @(posedge clk) if (MemWrite) mem[adr[11:2]] <= writeData;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // scoreboard: memory results at done, output registers one cycle later
  always @(negedge clk) begin
    if (pend) begin
      check("max_value", maxValue, pexp.v);
      check("max_index", maxIndex, pexp.x);
      pend = 0;
    end
    if (done) begin
      if (q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else begin
        pexp = q.pop_front();
        check("mem500", mem[500], pexp.v);
        check("mem501", mem[501], pexp.x);
        pend = 1;
      end
    end
  end

  function automatic exp_t model(input int n);
    exp_t e;
    e.v = 0;
    e.x = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++)
      if (i == 0 || $signed(vbuf[i]) > $signed(e.v)) begin
        e.v = vbuf[i];
        e.x = i;
      end
    return e;
  endfunction

  task automatic run_scan(input int n, input int restart_k);
    int k, reads, writes, nobusy;
    for (int i = 0; i < n; i++) mem[250+i] = vbuf[i];
    q.push_back(model(n));
    @(negedge clk);
    len = 16'(n);
    start = 1;
    @(negedge clk);
    k = 1; reads = 0; writes = 0; nobusy = 0;
    while (!done && k < n + 10) begin
      start = (k == restart_k);
      if (k == restart_k) len = 16'd1;
      nobusy += !busy;
      reads += MemRead;
      writes += MemWrite;
      @(negedge clk);
      k++;
    end
    start = 0;
    check("latency", k, n + 3);
    check("busy_gap", nobusy, 0);
    check("busy_at_done", busy, 1);
    check("reads", reads, n);
    check("writes", writes, 2);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("busy_after", busy, 0);
  endtask

  initial begin
    int k, dn1, dn2, wr;
    logic [31:0] s500, s501;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA5A5_0000 + i;
    #2;
    check("rst_adr", adr, 0);
    check("rst_wdata", writeData, 0);
    check("rst_ctrl", {28'd0, MemRead, MemWrite, busy, done}, 0);
    check("rst_maxv", maxValue, 0);
    check("rst_maxi", maxIndex, 0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    vbuf[0] = 3; vbuf[1] = -7; vbuf[2] = 12; vbuf[3] = 12; vbuf[4] = 5;
    run_scan(5, 0);
    vbuf[0] = -9; vbuf[1] = -2; vbuf[2] = -5;
    run_scan(3, 0);
    run_scan(0, 0);
    vbuf[0] = 1; vbuf[1] = 9; vbuf[2] = 4; vbuf[3] = 9; vbuf[4] = 2;
    run_scan(5, 2);
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) vbuf[i] = $urandom;
      run_scan(n, 0);
    end
    // start held high: two scans of len 2 with one idle cycle between
    vbuf[0] = 5; vbuf[1] = 6;
    mem[250] = 5; mem[251] = 6;
    q.push_back(model(2));
    q.push_back(model(2));
    @(negedge clk);
    len = 2; start = 1;
    dn1 = 0; dn2 = 0;
    for (k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 7) start = 0;
      if (done && dn1 == 0) dn1 = k;
      else if (done) dn2 = k;
      if (k == 6) check("held_idle", busy, 0);
      if (k == 7) check("held_rescan", MemRead, 1);
    end
    check("held_done1", dn1, 5);
    check("held_done2", dn2, 11);
    // reset during SCAN at i=2
    s500 = mem[500]; s501 = mem[501];
    for (int i = 0; i < 5; i++) mem[250+i] = 100 + i;
    @(negedge clk);
    len = 5; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk); @(negedge clk);
    check("abort_adr_i2", adr, 1008);
    check("abort_read", MemRead, 1);
    rst = 1;
    #1;
    check("abort_adr", adr, 0);
    check("abort_wdata", writeData, 0);
    check("abort_ctrl", {28'd0, MemRead, MemWrite, busy, done}, 0);
    check("abort_maxv", maxValue, 0);
    check("abort_maxi", maxIndex, 0);
    wr = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr += MemWrite;
    end
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wr += MemWrite + busy;
    end
    check("abort_nowrite", wr, 0);
    check("abort_m500", mem[500], s500);
    check("abort_m501", mem[501], s501);
    check("sb_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
